// File: rtl/led_tx_pkg.sv
// Shared types and default constants for the LED serial transmitter.
package led_tx_pkg;

  localparam int unsigned LED_WIDTH   = 6;
  localparam int unsigned LED_CLK_DIV = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

endpackage

// File: rtl/led_tx_tick.sv
// Phase counter: tick_c pulses on the last of every CLK_DIV cycles; restart holds it at zero.
module led_tx_tick #(
  parameter int unsigned CLK_DIV = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == CNT_W'(CLK_DIV - 1));

  // Wrapping on tick keeps consecutive phases aligned without an explicit restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_serial_tx.sv
// Serializes a WIDTH-bit LED frame onto sdata/sclk and strobes latch at the end.
// Bit order is MSB first by default; define LED_TX_LSB_FIRST_EN for LSB first.
module led_serial_tx
  import led_tx_pkg::*;
#(
  parameter int unsigned WIDTH   = LED_WIDTH,
  parameter int unsigned CLK_DIV = LED_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdata,
  output logic             sclk,
  output logic             latch,
  output logic             busy
);

  localparam int unsigned BIT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_cnt_nxt;
  logic             tick_c;
  logic             sdata_nxt;
  logic             sclk_nxt;
  logic             latch_nxt;
  logic             busy_nxt;

  led_tx_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (state == IDLE),
    .tick_c  (tick_c)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      sdata      <= 1'b0;
      sclk       <= 1'b0;
      latch      <= 1'b0;
      busy       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      sdata      <= sdata_nxt;
      sclk       <= sclk_nxt;
      latch      <= latch_nxt;
      busy       <= busy_nxt;
      load_ready <= ~busy_nxt;
    end
  end

  // Next state; outputs are decoded from the next state so they line up with it.
  always_comb begin
    logic             head;
    logic [WIDTH-1:0] shifted;
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
`ifdef LED_TX_LSB_FIRST_EN
    shifted = shreg >> 1;
`else
    shifted = shreg << 1;
`endif

    case (state)
      IDLE: begin
        if (load_valid) begin
          state_nxt   = SHIFT_LO;
          shreg_nxt   = load_data;
          bit_cnt_nxt = '0;
        end
      end
      SHIFT_LO: begin
        if (tick_c) state_nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (tick_c) begin
          shreg_nxt   = shifted;
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
          state_nxt   = (bit_cnt == BIT_W'(WIDTH - 1)) ? LATCH : SHIFT_LO;
        end
      end
      LATCH: begin
        if (tick_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

`ifdef LED_TX_LSB_FIRST_EN
    head = shreg_nxt[0];
`else
    head = shreg_nxt[WIDTH-1];
`endif

    sclk_nxt  = (state_nxt == SHIFT_HI);
    latch_nxt = (state_nxt == LATCH);
    busy_nxt  = (state_nxt != IDLE);
    sdata_nxt = ((state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI)) ? head : 1'b0;
  end

endmodule
